// File: rtl/hpi_pkg.sv
// hpi_pkg
// Shared definitions for the HPI transaction controller: the controller state
// encoding and the 2-bit HPI port numbers driven on hpi_address.
package hpi_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR_STB = 3'd1,
    GAP      = 3'd2,
    DATA_STB = 3'd3,
    RD_WAIT  = 3'd4,
    DONE     = 3'd5
  } hpi_state_e;

  // HPI port select values
  localparam logic [1:0] HPI_DATA    = 2'd0;
  localparam logic [1:0] HPI_MAILBOX = 2'd1;
  localparam logic [1:0] HPI_ADDRESS = 2'd2;
  localparam logic [1:0] HPI_STATUS  = 2'd3;

  // Read turnaround: pad output register + pad input register = 2 cycles
  localparam logic [3:0] RD_WAIT_LOAD = 4'd1;

endpackage

// File: rtl/hpi_txn_ctrl.sv
// hpi_txn_ctrl
// Turns one request (memory or direct-port, read or write) into the HPI strobe
// sequence: optional address phase on the ADDRESS port, a gap, the data phase,
// a read turnaround when reading, and a closing gap that ends with rsp_valid.
//
// Ports
//   Clk, Reset                 clock; asynchronous active-high reset
//   req_valid/req_ready        request handshake
//   req_write, req_direct      1 = write; 1 = single-phase port access
//   req_addr, req_wdata        chip address (port number in [1:0] if direct), write data
//   rsp_valid, rsp_rdata       one-cycle completion pulse; last read data
//   busy                       transaction in progress
//   hpi_address, hpi_data_out  port select and data toward the pad stage
//   hpi_data_in                read data returned by the pad stage
//   hpi_r, hpi_w, hpi_cs       active-low strobes
//   state_dbg                  current controller state (hpi_state_e encoding)
//
// Handshake: a request is taken on a rising edge where req_valid && req_ready;
// req_ready is high only while idle, and fields are captured on that edge.
//
// Every output is a flop loaded from the current state, so the pins follow the
// state register by one cycle. req_ready/busy are loaded from the idle/accept
// decision so a request can never be taken twice.
module hpi_txn_ctrl
  import hpi_pkg::*;
#(
  parameter int unsigned STROBE_CYCLES = 4,
  parameter int unsigned GAP_CYCLES    = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_direct,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        busy,
  output logic [1:0]  hpi_address,
  output logic [15:0] hpi_data_out,
  input  logic [15:0] hpi_data_in,
  output logic        hpi_r,
  output logic        hpi_w,
  output logic        hpi_cs,
  output logic [2:0]  state_dbg
);

  localparam logic [3:0] STB_LOAD = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

  hpi_state_e  state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        cap_write, cap_direct;
  logic [15:0] cap_addr, cap_wdata;
  logic        accept;

  logic        cs_d, r_d, w_d, rsp_valid_d, ready_d;
  logic [1:0]  address_d;
  logic [15:0] dout_d, rdata_d;

  assign accept    = req_valid && req_ready && (state == IDLE);
  assign state_dbg = state;

  // Next state and counter; the counter is reloaded with (duration-1) on
  // every state entry and each state exits when it reaches zero.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = req_direct ? DATA_STB : ADDR_STB;
          cnt_nxt   = STB_LOAD;
        end
      end
      ADDR_STB: begin
        if (cnt == 4'd0) begin
          state_nxt = GAP;
          cnt_nxt   = GAP_LOAD;
        end else cnt_nxt = cnt - 4'd1;
      end
      GAP: begin
        if (cnt == 4'd0) begin
          state_nxt = DATA_STB;
          cnt_nxt   = STB_LOAD;
        end else cnt_nxt = cnt - 4'd1;
      end
      DATA_STB: begin
        if (cnt == 4'd0) begin
          state_nxt = cap_write ? DONE : RD_WAIT;
          cnt_nxt   = cap_write ? GAP_LOAD : RD_WAIT_LOAD;
        end else cnt_nxt = cnt - 4'd1;
      end
      RD_WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = DONE;
          cnt_nxt   = GAP_LOAD;
        end else cnt_nxt = cnt - 4'd1;
      end
      DONE: begin
        if (cnt == 4'd0) begin
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end else cnt_nxt = cnt - 4'd1;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Output values for the next cycle. Address and data only change on entry
  // into a strobe phase, which keeps them stable through the strobe and the
  // cycle after release. Only ADDR_STB/DATA_STB lower cs, and a data phase
  // lowers exactly one of r/w.
  always_comb begin
    cs_d        = !(state == ADDR_STB || state == DATA_STB);
    w_d         = !(state == ADDR_STB || (state == DATA_STB && cap_write));
    r_d         = !(state == DATA_STB && !cap_write);
    address_d   = hpi_address;
    dout_d      = hpi_data_out;
    rdata_d     = rsp_rdata;
    rsp_valid_d = (state == DONE) && (cnt == 4'd0);
    ready_d     = (state == IDLE) && !accept;
    if (state == ADDR_STB) begin
      address_d = HPI_ADDRESS;
      dout_d    = cap_addr;
    end
    if (state == DATA_STB) begin
      address_d = cap_direct ? cap_addr[1:0] : HPI_DATA;
      if (cap_write) dout_d = cap_wdata;
    end
    if (state == RD_WAIT && cnt == 4'd0) rdata_d = hpi_data_in;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      cap_write    <= 1'b0;
      cap_direct   <= 1'b0;
      cap_addr     <= 16'd0;
      cap_wdata    <= 16'd0;
      hpi_cs       <= 1'b1;
      hpi_r        <= 1'b1;
      hpi_w        <= 1'b1;
      hpi_address  <= 2'd0;
      hpi_data_out <= 16'd0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= 16'd0;
      req_ready    <= 1'b1;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      if (accept) begin
        cap_write  <= req_write;
        cap_direct <= req_direct;
        cap_addr   <= req_addr;
        cap_wdata  <= req_wdata;
      end
      hpi_cs       <= cs_d;
      hpi_r        <= r_d;
      hpi_w        <= w_d;
      hpi_address  <= address_d;
      hpi_data_out <= dout_d;
      rsp_valid    <= rsp_valid_d;
      rsp_rdata    <= rdata_d;
      req_ready    <= ready_d;
      busy         <= !ready_d;
    end
  end

endmodule

// File: tb/tb_hpi_txn_ctrl.sv
// tb_hpi_txn_ctrl
// Bench for hpi_txn_ctrl (S=4, G=2). A pad-stage model returns read data two
// cycles behind the read strobe. Each transaction's pin trace is compared
// against a timeline derived from phase durations and end-to-end latency.
module tb_hpi_txn_ctrl;
  import hpi_pkg::*;

  localparam int S = 4;
  localparam int G = 2;

  // clock / reset
  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  logic        req_valid, req_ready, req_write, req_direct;
  logic [15:0] req_addr, req_wdata;
  logic        rsp_valid, busy;
  logic [15:0] rsp_rdata;
  logic [1:0]  hpi_address;
  logic [15:0] hpi_data_out, hpi_data_in;
  logic        hpi_r, hpi_w, hpi_cs;
  logic [2:0]  state_dbg;

  hpi_txn_ctrl #(.STROBE_CYCLES(S), .GAP_CYCLES(G)) dut (
    .Clk(Clk), .Reset(Reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_direct(req_direct), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .hpi_address(hpi_address), .hpi_data_out(hpi_data_out), .hpi_data_in(hpi_data_in),
    .hpi_r(hpi_r), .hpi_w(hpi_w), .hpi_cs(hpi_cs), .state_dbg(state_dbg)
  );

  // pad stage: data appears two cycles after the read strobe, junk otherwise
  logic        r_d1 = 1'b1;
  logic [15:0] pad_val = 16'd0;
  always @(posedge Clk) begin
    r_d1        <= hpi_r;
    hpi_data_in <= (!r_d1) ? pad_val : 16'($urandom);
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver
  task automatic present(input logic wr, input logic dir, input logic [15:0] a, input logic [15:0] d);
    req_write  = wr;
    req_direct = dir;
    req_addr   = a;
    req_wdata  = d;
    req_valid  = 1'b1;
  endtask

  // called at a negedge with a request presented; returns just after the accepting edge
  task automatic wait_accept();
    int n = 0;
    while (!req_ready && n < 40) begin
      @(negedge Clk);
      n++;
    end
    check("accept_within_bound", 32'(n < 40), 32'd1);
    @(posedge Clk);
  endtask

  // per-cycle samples of a transaction, index = cycles after acceptance
  logic        s_cs[0:63], s_r[0:63], s_w[0:63], s_busy[0:63], s_rdy[0:63], s_rsp[0:63];
  logic [1:0]  s_addr[0:63];
  logic [15:0] s_dout[0:63], s_rd[0:63];

  logic [15:0] model_rd = 16'd0;
  logic        nxt_wr, nxt_dir;
  logic [15:0] nxt_a, nxt_d;

  // scoreboard expected response queue
  logic [15:0] exp_q[$];

  task automatic run_txn(input logic wr, input logic dir, input logic [15:0] a,
                         input logic [15:0] d, input logic [15:0] rdv, input bit keep);
    int exp_lat, done_start, data_start, addr_start, lat;
    int bad_strobe, bad_addr, bad_dout, overlap, bad_ctl;
    logic [1:0] port;
    logic in_a, in_d, e_cs, e_r, e_w;
    logic [15:0] exp_rd;
    // reference timeline from phase durations
    exp_lat    = (dir ? 0 : S + G) + S + G + 1 + (wr ? 0 : 2);
    done_start = exp_lat - G + 1;
    data_start = done_start - (wr ? 0 : 2) - S;
    addr_start = data_start - G - S;
    port       = dir ? a[1:0] : HPI_DATA;
    if (!wr) model_rd = rdv;
    exp_q.push_back(model_rd);
    pad_val = rdv;
    wait_accept();
    lat = 0;
    for (int k = 1; k <= exp_lat + 1; k++) begin
      @(negedge Clk);
      s_cs[k] = hpi_cs; s_r[k] = hpi_r; s_w[k] = hpi_w; s_addr[k] = hpi_address;
      s_dout[k] = hpi_data_out; s_rd[k] = rsp_rdata; s_busy[k] = busy;
      s_rdy[k] = req_ready; s_rsp[k] = rsp_valid;
      if (rsp_valid && lat == 0) lat = k;
      if (k == 1) begin
        if (keep) present(nxt_wr, nxt_dir, nxt_a, nxt_d);
        else begin
          req_valid = 1'b0;
          req_write = 1'($urandom); req_direct = 1'($urandom);
          req_addr = 16'($urandom); req_wdata = 16'($urandom);
        end
      end
    end
    bad_strobe = 0; bad_addr = 0; bad_dout = 0; overlap = 0; bad_ctl = 0;
    for (int k = 1; k <= exp_lat + 1; k++) begin
      in_a = !dir && k >= addr_start && k < addr_start + S;
      in_d = k >= data_start && k < data_start + S;
      e_cs = !(in_a || in_d);
      e_w  = !(in_a || (in_d && wr));
      e_r  = !(in_d && !wr);
      if ({s_cs[k], s_r[k], s_w[k]} !== {e_cs, e_r, e_w}) bad_strobe++;
      if (s_r[k] == 1'b0 && s_w[k] == 1'b0) overlap++;
      if (s_r[k] && s_w[k] && !s_cs[k]) overlap++;
      if (!dir && k >= addr_start && k <= addr_start + S) begin
        if (s_addr[k] !== HPI_ADDRESS) bad_addr++;
        if (s_dout[k] !== a) bad_dout++;
      end
      if (k >= data_start && k <= data_start + S) begin
        if (s_addr[k] !== port) bad_addr++;
        if (wr && s_dout[k] !== d) bad_dout++;
      end
      if (s_busy[k] !== (k <= exp_lat)) bad_ctl++;
      if (s_rdy[k] !== (k > exp_lat)) bad_ctl++;
      if (s_rsp[k] !== (k == exp_lat)) bad_ctl++;
    end
    exp_rd = exp_q.pop_front();
    check("latency", 32'(lat), 32'(exp_lat));
    check("strobe_trace_bad_cycles", 32'(bad_strobe), 32'd0);
    check("rw_overlap_or_cs", 32'(overlap), 32'd0);
    check("hpi_address_bad_cycles", 32'(bad_addr), 32'd0);
    check("hpi_data_out_bad_cycles", 32'(bad_dout), 32'd0);
    check("busy_ready_rsp_bad_cycles", 32'(bad_ctl), 32'd0);
    check("rsp_rdata", 32'(s_rd[exp_lat]), 32'(exp_rd));
  endtask

  initial begin
    int rsp_seen;
    int gap;
    Reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_direct = 1'b0;
    req_addr = 16'd0; req_wdata = 16'd0;
    #1;
    check("rst_cs", 32'(hpi_cs), 32'd1);
    check("rst_rw", 32'({hpi_r, hpi_w}), 32'd3);
    check("rst_addr", 32'(hpi_address), 32'd0);
    check("rst_dout", 32'(hpi_data_out), 32'd0);
    check("rst_rsp", 32'({rsp_valid, busy, req_ready}), 32'b001);
    check("rst_rdata", 32'(rsp_rdata), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);

    // memory write
    present(1'b1, 1'b0, 16'h0500, 16'hBEEF);
    run_txn(1'b1, 1'b0, 16'h0500, 16'hBEEF, 16'h0000, 1'b0);
    // memory read
    present(1'b0, 1'b0, 16'h0140, 16'h0000);
    run_txn(1'b0, 1'b0, 16'h0140, 16'h0000, 16'h1234, 1'b0);
    // direct read of STATUS
    present(1'b0, 1'b1, 16'h0003, 16'h0000);
    run_txn(1'b0, 1'b1, 16'h0003, 16'h0000, 16'h0001, 1'b0);
    // direct write to MAILBOX
    present(1'b1, 1'b1, 16'hFFF1, 16'h55AA);
    run_txn(1'b1, 1'b1, 16'hFFF1, 16'h55AA, 16'h0000, 1'b0);

    // back-to-back writes with req_valid held high
    nxt_wr = 1'b1; nxt_dir = 1'b0; nxt_a = 16'h0600; nxt_d = 16'hCAFE;
    present(1'b1, 1'b0, 16'h0502, 16'h1111);
    run_txn(1'b1, 1'b0, 16'h0502, 16'h1111, 16'h0000, 1'b1);
    check("b2b_ready_after_rsp", 32'({req_valid, req_ready}), 32'b11);
    run_txn(1'b1, 1'b0, 16'h0600, 16'hCAFE, 16'h0000, 1'b0);

    // reset during the second cycle of a read data strobe
    @(negedge Clk);
    present(1'b0, 1'b0, 16'h0222, 16'h0000);
    pad_val = 16'h5A5A;
    wait_accept();
    #1 req_valid = 1'b0;
    repeat (8) @(posedge Clk);
    #1;
    check("rst_mid_strobe_active", 32'(hpi_r), 32'd0);
    Reset = 1'b1;
    #1;
    check("rst_mid_strobes_high", 32'({hpi_cs, hpi_r, hpi_w}), 32'b111);
    check("rst_mid_rdata", 32'(rsp_rdata), 32'd0);
    check("rst_mid_ctl", 32'({rsp_valid, busy, req_ready}), 32'b001);
    @(negedge Clk);
    Reset = 1'b0;
    model_rd = 16'd0;
    rsp_seen = 0;
    repeat (20) begin
      @(negedge Clk);
      if (rsp_valid) rsp_seen++;
    end
    check("rst_mid_no_rsp", 32'(rsp_seen), 32'd0);
    present(1'b0, 1'b0, 16'h0222, 16'h0000);
    run_txn(1'b0, 1'b0, 16'h0222, 16'h0000, 16'h6B6B, 1'b0);

    // randomized transactions
    for (int i = 0; i < 20; i++) begin
      logic wr, dir;
      logic [15:0] a, d, v;
      wr = 1'($urandom); dir = 1'($urandom);
      a = 16'($urandom); d = 16'($urandom); v = 16'($urandom);
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge Clk);
      present(wr, dir, a, d);
      run_txn(wr, dir, a, d, v, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
